// File: rtl/dp_mem_bist_if.sv
// Request/response bus between the BIST initiator (master) and a dual-port memory (slave).
// The write and read ports share one request qualifier; read data returns on mem_ready.
interface dp_mem_bist_if #(
  parameter int DATA_SIZE  = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  mem_valid;
  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_w_addr;
  logic [DATA_SIZE-1:0]  mem_w_data;
  logic [ADDR_WIDTH-1:0] mem_r_addr;
  logic [DATA_SIZE-1:0]  mem_r_data;
  logic                  mem_ready;

  modport master (
    output mem_valid, mem_we, mem_re, mem_w_addr, mem_w_data, mem_r_addr,
    input  mem_r_data, mem_ready
  );

  modport slave (
    input  mem_valid, mem_we, mem_re, mem_w_addr, mem_w_data, mem_r_addr,
    output mem_r_data, mem_ready
  );
endinterface

// File: rtl/dp_mem_bist.sv
// March BIST for a dual-port memory: write A, verify A, write ~A, verify ~A.
// All outputs are registered and computed from the next state, so idle buses hold their last values.
module dp_mem_bist #(
  parameter int                   DATA_SIZE  = 32,
  parameter int                   ADDR_WIDTH = 4,
  parameter logic [DATA_SIZE-1:0] PATTERN    = DATA_SIZE'(32'hA5A5_0000),
  parameter int                   TIMEOUT    = 8,
  parameter int                   ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_SIZE-1:0]  fail_data,
  dp_mem_bist_if.master         mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_A,
    S_RD_ISSUE_A,
    S_RD_WAIT_A,
    S_WR_B,
    S_RD_ISSUE_B,
    S_RD_WAIT_B,
    S_DONE
  } state_t;

  localparam int                    TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]         T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ERR_W-1:0]      ERR_MAX  = '1;

  function automatic logic [DATA_SIZE-1:0] pattern_of(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic                  inv);
    logic [DATA_SIZE-1:0] p;
    p = PATTERN ^ DATA_SIZE'(a);
    return inv ? ~p : p;
  endfunction

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] addr, addr_d;
  logic [TW-1:0]         tcnt, tcnt_d;
  logic [ERR_W-1:0]      err_d;
  logic [ADDR_WIDTH-1:0] fail_addr_d;
  logic [DATA_SIZE-1:0]  fail_data_d;
  logic                  busy_d, done_d, pass_d;
  logic                  valid_d, we_d, re_d;
  logic [ADDR_WIDTH-1:0] w_addr_d, r_addr_d;
  logic [DATA_SIZE-1:0]  w_data_d;
  logic                  phase_b;
  logic                  rd_done, rd_err;
  logic [DATA_SIZE-1:0]  rd_data;

  assign phase_b = (state == S_WR_B) || (state == S_RD_ISSUE_B) || (state == S_RD_WAIT_B);

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d     = state;
    addr_d      = addr;
    tcnt_d      = tcnt;
    err_d       = err_count;
    fail_addr_d = fail_addr;
    fail_data_d = fail_data;
    rd_done     = 1'b0;
    rd_err      = 1'b0;
    rd_data     = '0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d       = '0;
          fail_addr_d = '0;
          fail_data_d = '0;
          addr_d      = '0;
          state_d     = S_WR_A;
        end
      end

      S_WR_A, S_WR_B: begin
        addr_d = addr + 1'b1;
        if (addr == ADDR_MAX) state_d = phase_b ? S_RD_ISSUE_B : S_RD_ISSUE_A;
      end

      S_RD_ISSUE_A, S_RD_ISSUE_B: begin
        tcnt_d  = '0;
        state_d = phase_b ? S_RD_WAIT_B : S_RD_WAIT_A;
      end

      S_RD_WAIT_A, S_RD_WAIT_B: begin
        tcnt_d = tcnt + 1'b1;
        // A late mem_ready on the last waiting cycle still counts as a response.
        if (mem.mem_ready) begin
          rd_done = 1'b1;
          rd_data = mem.mem_r_data;
          rd_err  = (mem.mem_r_data != pattern_of(addr, phase_b));
        end else if (tcnt == T_LAST) begin
          rd_done = 1'b1;
          rd_err  = 1'b1;
        end

        if (rd_done) begin
          if (rd_err) begin
            if (err_count == '0) begin
              fail_addr_d = addr;
              fail_data_d = rd_data;
            end
            if (err_count != ERR_MAX) err_d = err_count + 1'b1;
          end
          addr_d = addr + 1'b1;
          if (addr == ADDR_MAX) state_d = phase_b ? S_DONE : S_WR_B;
          else                  state_d = phase_b ? S_RD_ISSUE_B : S_RD_ISSUE_A;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered outputs are derived from where the FSM is heading next.
    valid_d  = (state_d == S_WR_A) || (state_d == S_WR_B) ||
               (state_d == S_RD_ISSUE_A) || (state_d == S_RD_ISSUE_B);
    we_d     = (state_d == S_WR_A) || (state_d == S_WR_B);
    re_d     = (state_d == S_RD_ISSUE_A) || (state_d == S_RD_ISSUE_B);
    w_addr_d = we_d ? addr_d : mem.mem_w_addr;
    w_data_d = we_d ? pattern_of(addr_d, state_d == S_WR_B) : mem.mem_w_data;
    r_addr_d = re_d ? addr_d : mem.mem_r_addr;
    busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d   = (state_d == S_DONE);
    pass_d   = done_d && (err_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      addr           <= '0;
      tcnt           <= '0;
      err_count      <= '0;
      fail_addr      <= '0;
      fail_data      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mem.mem_valid  <= 1'b0;
      mem.mem_we     <= 1'b0;
      mem.mem_re     <= 1'b0;
      mem.mem_w_addr <= '0;
      mem.mem_w_data <= '0;
      mem.mem_r_addr <= '0;
    end else begin
      state          <= state_d;
      addr           <= addr_d;
      tcnt           <= tcnt_d;
      err_count      <= err_d;
      fail_addr      <= fail_addr_d;
      fail_data      <= fail_data_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      mem.mem_valid  <= valid_d;
      mem.mem_we     <= we_d;
      mem.mem_re     <= re_d;
      mem.mem_w_addr <= w_addr_d;
      mem.mem_w_data <= w_data_d;
      mem.mem_r_addr <= r_addr_d;
    end
  end

endmodule

// File: tb/tb_dp_mem_bist.sv
// Bench for dp_mem_bist: behavioural memory with random latency and injectable stuck-at faults,
// plus a reference model that predicts the error log from the march rules.
module tb_dp_mem_bist;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, pass;
  logic [7:0]  err_count;
  logic [3:0]  fail_addr;
  logic [31:0] fail_data;

  dp_mem_bist_if #(.DATA_SIZE(32), .ADDR_WIDTH(4)) mif ();

  dp_mem_bist #(
    .DATA_SIZE(32), .ADDR_WIDTH(4), .PATTERN(PAT), .TIMEOUT(8), .ERR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data), .mem(mif.master)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Memory model configuration
  int         lat_min = 1, lat_max = 1;
  logic       no_ready = 1'b0;
  logic       fault_en = 1'b0;
  logic [3:0] faddr    = '0;
  int         fbit     = 0;
  logic       fval     = 1'b0;

  logic [31:0] mem_arr [16];
  logic        pend, outstanding;
  int          pend_cnt;
  logic [3:0]  pend_addr;
  int          extra_re = 0;
  int          cyc = 0;
  logic [63:0] wq[$];

  function automatic logic [31:0] rd(input logic [3:0] a);
    logic [31:0] d;
    d = mem_arr[a];
    if (fault_en && a == faddr) d[fbit] = fval;
    return d;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    int lat;
    if (rst) begin
      mif.mem_ready  <= 1'b0;
      mif.mem_r_data <= '0;
      pend           <= 1'b0;
      pend_cnt       <= 0;
      pend_addr      <= '0;
      outstanding    <= 1'b0;
    end else begin
      mif.mem_ready <= 1'b0;
      if (mif.mem_valid && mif.mem_we) begin
        mem_arr[mif.mem_w_addr] <= mif.mem_w_data;
        wq.push_back({32'(cyc), mif.mem_w_data});
      end
      if (mif.mem_ready) outstanding <= 1'b0;
      if (mif.mem_valid && mif.mem_re) begin
        if (outstanding || pend) extra_re <= extra_re + 1;
        outstanding <= !no_ready;
        if (!no_ready) begin
          lat = int'($urandom_range(lat_max, lat_min));
          if (lat == 1) begin
            mif.mem_ready  <= 1'b1;
            mif.mem_r_data <= rd(mif.mem_r_addr);
          end else begin
            pend      <= 1'b1;
            pend_cnt  <= lat - 1;
            pend_addr <= mif.mem_r_addr;
          end
        end
      end else if (pend) begin
        if (pend_cnt == 1) begin
          pend           <= 1'b0;
          mif.mem_ready  <= 1'b1;
          mif.mem_r_data <= rd(pend_addr);
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk both march phases over every address and log what a faulty read would give.
  task automatic model(output int e_err, output logic [3:0] e_faddr, output logic [31:0] e_fdata);
    e_err = 0; e_faddr = '0; e_fdata = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < 16; a++) begin
        logic [31:0] want, got;
        want = PAT ^ 32'(a);
        if (ph == 1) want = ~want;
        got = want;
        if (fault_en && a == int'(faddr)) got[fbit] = fval;
        if (no_ready) got = '0;
        if (no_ready || got != want) begin
          if (e_err == 0) begin
            e_faddr = a[3:0];
            e_fdata = got;
          end
          if (e_err < 255) e_err++;
        end
      end
    end
  endtask

  task automatic run_test(input int busy_pulse_at, output int cycles,
                          output logic [7:0] err_at1, output logic done_at1);
    int n;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 1;
    err_at1  = err_count;
    done_at1 = done;
    while (!done && n < 3000) begin
      @(negedge clk);
      start = (n == busy_pulse_at);
      n++;
    end
    start  = 1'b0;
    cycles = done ? n - 1 : -1;
  endtask

  task automatic check_vs_model(input string tag);
    int          e_err;
    logic [3:0]  e_fa;
    logic [31:0] e_fd;
    model(e_err, e_fa, e_fd);
    check({tag, "_done"},  64'(done), 64'd1);
    check({tag, "_err"},   64'(err_count), 64'(e_err));
    check({tag, "_pass"},  64'(pass), 64'(e_err == 0));
    if (e_err != 0) begin
      check({tag, "_faddr"}, 64'(fail_addr), 64'(e_fa));
      check({tag, "_fdata"}, 64'(fail_data), 64'(e_fd));
    end
  endtask

  initial begin
    int          cycles, base_w, base_x, k;
    logic [7:0]  e1;
    logic        d1;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctl",   64'({busy, done, pass, err_count, fail_addr}), 64'd0);
    check("rst_fdata", 64'(fail_data), 64'd0);
    check("rst_bus",   64'({mif.mem_valid, mif.mem_we, mif.mem_re, mif.mem_w_addr, mif.mem_r_addr}), 64'd0);
    check("rst_wdata", 64'(mif.mem_w_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Good memory, 1-cycle latency: timing and write sequence
    base_w = wq.size();
    run_test(0, cycles, e1, d1);
    check("good_cycles", 64'(cycles), 64'd96);
    check("good_busy",   64'(busy), 64'd0);
    check_vs_model("good");
    check("good_nwrites", 64'(wq.size() - base_w), 64'd32);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("wr_data_%0d", i), 64'(wq[base_w + i][31:0]), 64'(PAT + 32'(i)));
      check($sformatf("wr_cyc_%0d", i), 64'(wq[base_w + i][63:32] - wq[base_w][63:32]), 64'(i));
    end

    // Stuck-at-1 on address 5 bit 0: only the ~A phase sees it
    fault_en = 1'b1; faddr = 4'd5; fbit = 0; fval = 1'b1;
    run_test(0, cycles, e1, d1);
    check("sa_err",   64'(err_count), 64'd1);
    check("sa_faddr", 64'(fail_addr), 64'd5);
    check("sa_fdata", 64'(fail_data), 64'h5A5A_FFFB);
    check("sa_pass",  64'(pass), 64'd0);
    check_vs_model("sa");

    // No response at all: every read times out
    fault_en = 1'b0; no_ready = 1'b1;
    run_test(0, cycles, e1, d1);
    check("to_cleared", 64'(e1), 64'd0);
    check("to_err",   64'(err_count), 64'd32);
    check("to_faddr", 64'(fail_addr), 64'd0);
    check("to_fdata", 64'(fail_data), 64'd0);
    check("to_pass",  64'(pass), 64'd0);
    check("to_cycles", 64'(cycles), 64'(2 * 16 + 32 * 9));

    // Variable latency, restarted from DONE after a failing run
    no_ready = 1'b0; lat_min = 1; lat_max = 5;
    base_x = extra_re;
    run_test(0, cycles, e1, d1);
    check("var_clr_err",  64'(e1), 64'd0);
    check("var_clr_done", 64'(d1), 64'd0);
    check_vs_model("var");
    check("var_extra_re", 64'(extra_re - base_x), 64'd0);

    // Random single stuck-at faults under random latency
    for (int t = 0; t < 4; t++) begin
      fault_en = 1'b1;
      faddr    = 4'($urandom_range(15, 0));
      fbit     = int'($urandom_range(31, 0));
      fval     = 1'($urandom_range(1, 0));
      run_test(0, cycles, e1, d1);
      check_vs_model($sformatf("rnd%0d", t));
    end
    fault_en = 1'b0;

    // start while busy is ignored
    lat_min = 1; lat_max = 1;
    run_test(30, cycles, e1, d1);
    check("busy_start_cycles", 64'(cycles), 64'd96);
    check_vs_model("busy_start");

    // Asynchronous reset in the middle of RD_WAIT_A
    lat_min = 4; lat_max = 4;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 0;
    while (!mif.mem_re && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("mid_found_issue", 64'(k < 100), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ctl",   64'({busy, done, pass, err_count, fail_addr}), 64'd0);
    check("mid_rst_fdata", 64'(fail_data), 64'd0);
    check("mid_rst_bus",   64'({mif.mem_valid, mif.mem_we, mif.mem_re, mif.mem_w_addr, mif.mem_r_addr}), 64'd0);
    check("mid_rst_wdata", 64'(mif.mem_w_data), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_no_done", 64'({done, busy}), 64'd0);
    lat_min = 1; lat_max = 3;
    run_test(0, cycles, e1, d1);
    check_vs_model("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dp_mem_bist.md
Name: dp_mem_bist

Overview:
- Built-in self-test initiator for the dual-port memory (dp_memory); drives its write and read ports and checks the returned data.
- Runs a four-phase march: write pattern A, read/verify A, write pattern B = ~A, read/verify B.
- Reports pass/fail, error count and first failing address/data.
- Sits between the test/control logic and a dp_memory instance; muxing with functional traffic is outside this block.

Parameters:
DATA_SIZE, 32, memory word width
ADDR_WIDTH, 4, memory address width; depth = 2**ADDR_WIDTH
PATTERN, 32'hA5A5_0000, base data seed (DATA_SIZE bits)
TIMEOUT, 8, max cycles to wait for mem_ready after a read request (>=2)
ERR_W, 8, width of err_count

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  launch test; sampled in IDLE or DONE
busy  out  1  high while a test runs
done  out  1  high in DONE until the next start
pass  out  1  valid when done=1; 1 = err_count==0
err_count  out  ERR_W  mismatches plus timeouts, saturating
fail_addr  out  ADDR_WIDTH  address of first error
fail_data  out  DATA_SIZE  data read at first error (0 on timeout)
mem_valid  out  1  request qualifier to memory
mem_we  out  1  write enable
mem_re  out  1  read enable
mem_w_addr  out  ADDR_WIDTH  write address
mem_w_data  out  DATA_SIZE  write data
mem_r_addr  out  ADDR_WIDTH  read address
mem_r_data  in  DATA_SIZE  read data
mem_ready  in  1  read data valid strobe

Behaviour:
- Reset (async, rst=1): state=IDLE; every output is 0. Mid-test reset aborts immediately with no completion.
- Memory contract: a write takes effect at the edge where mem_valid&mem_we=1; no handshake. A read is requested by one cycle of mem_valid&mem_re. The memory returns mem_r_data with mem_ready=1 on some later cycle. mem_ready outside RD_WAIT is ignored.
- Patterns: A(addr) = PATTERN ^ zero-extended addr. B(addr) = ~A(addr).
- States: IDLE, WR_A, RD_ISSUE_A, RD_WAIT_A, WR_B, RD_ISSUE_B, RD_WAIT_B, DONE.
- IDLE/DONE with start=1: clear err_count, fail_addr, fail_data, done and pass; set addr=0 and busy=1; go to WR_A.
- WR_x:
  - mem_valid=1, mem_we=1, mem_re=0, mem_w_addr=addr, mem_w_data=pattern(addr).
  - One word per cycle. addr increments each cycle.
  - At addr=max, addr wraps to 0 and the state moves to RD_ISSUE_x.
- RD_ISSUE_x: mem_valid=1, mem_re=1, mem_we=0, mem_r_addr=addr, for one cycle. Clear the timeout counter. Go to RD_WAIT_x.
- RD_WAIT_x: mem_valid=0, mem_r_addr held.
  - When mem_ready=1: compare mem_r_data to pattern(addr).
  - When no mem_ready has arrived TIMEOUT cycles after entry: record an error with fail_data=0.
  - Either exit: if addr=max, wrap addr to 0 and go to WR_B (from A) or DONE (from B); otherwise addr++ and return to RD_ISSUE_x.
- Error logging: err_count increments and saturates at 2**ERR_W-1. fail_addr and fail_data are captured only on the first error.
- DONE: busy=0, done=1, pass=(err_count==0). Outputs hold until start or rst.
- start while busy is ignored.
- Outputs when idle: mem_valid, mem_we and mem_re are 0 whenever not in WR/RD_ISSUE. Addresses and data hold their last values.
- Timing: with a 1-cycle-latency memory the test takes 3*2**ADDR_WIDTH*2 cycles from the start-sampling edge to DONE. For ADDR_WIDTH=4 that is 96 cycles.

Test Plan:
- Good memory, 1-cycle read latency, ADDR_WIDTH=4: start for one cycle -> mem_we high 16 consecutive cycles with w_data A5A5_0000..A5A5_000F; DONE reached exactly 96 cycles after start is sampled; pass=1, err_count=0.
- Memory with addr 5 bit 0 stuck-at-1: pass=0; err_count=1 (B phase only); fail_addr=5; fail_data=5A5A_FFFB.
- mem_ready never asserted: each read times out after 8 cycles; err_count=32; fail_addr=0; fail_data=0; pass=0.
- Variable read latency of 1..5 cycles: pass=1; no extra re pulses while in RD_WAIT.
- rst asserted mid RD_WAIT_A: all outputs 0 immediately (same cycle, async). A later start reruns the test to pass=1.
- start asserted while busy: no effect. start asserted in DONE: counters cleared and a new run completes with pass=1.
